// File: rtl/md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_pkg : shared types and latencies for the HI/LO multiply-divide unit|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package md_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } md_state_t;

    localparam logic [3:0] MD_MULT_LAT = 4'd5;
    localparam logic [3:0] MD_DIV_LAT  = 4'd10;

    function automatic logic is_signed_op(input md_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_arith : combinational 32x32 product and quotient/remainder        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module md_arith (
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        signed_i,
    output logic [63:0] prod_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic [63:0] w_rs_ext;
    logic [63:0] w_rt_ext;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    // Low 64 bits of the product are correct for both signednesses once extended.
    assign w_rs_ext = {{32{signed_i & rs_i[31]}}, rs_i};
    assign w_rt_ext = {{32{signed_i & rt_i[31]}}, rt_i};
    assign prod_o   = w_rs_ext * w_rt_ext;

    assign w_rs_neg = signed_i & rs_i[31];
    assign w_rt_neg = signed_i & rt_i[31];
    assign w_rs_mag = w_rs_neg ? (32'd0 - rs_i) : rs_i;
    assign w_rt_mag = w_rt_neg ? (32'd0 - rt_i) : rt_i;
    assign w_q_mag  = (w_rt_mag == 32'd0) ? 32'd0 : (w_rs_mag / w_rt_mag);
    assign w_r_mag  = (w_rt_mag == 32'd0) ? 32'd0 : (w_rs_mag % w_rt_mag);

    always_comb begin
        quot_o = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        rem_o  = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;
        if (rt_i == 32'd0) begin
            quot_o = 32'hFFFF_FFFF;
            rem_o  = rs_i;
        end else if (signed_i && rs_i == 32'h8000_0000 && rt_i == 32'hFFFF_FFFF) begin
            quot_o = 32'h8000_0000;
            rem_o  = 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/md_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_scheduler : HI/LO owner, multi-cycle MD sequencing and ID stall   |
// | Option: MD_DIV0_FAST_EN gives divide-by-zero a 1-cycle latency.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module md_scheduler
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        id_md_use,
    output logic        req_ready,
    output logic        busy,
    output logic        stall_id,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pending_q, pending_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    md_op_t      w_op;
    logic        w_long_op;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [3:0]  w_div_lat;

    assign w_op      = md_op_t'(req_op);
    assign w_long_op = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                       (w_op == OP_DIV)  || (w_op == OP_DIVU);

    md_arith u_arith (
        .rs_i     (rs_data),
        .rt_i     (rt_data),
        .signed_i (is_signed_op(w_op)),
        .prod_o   (w_prod),
        .quot_o   (w_quot),
        .rem_o    (w_rem)
    );

`ifdef MD_DIV0_FAST_EN
    assign w_div_lat = (rt_data == 32'd0) ? 4'd1 : MD_DIV_LAT;
`else
    assign w_div_lat = MD_DIV_LAT;
`endif

    assign busy      = (state_q != IDLE);
    assign req_ready = !busy;
    assign stall_id  = id_md_use & (busy | (req_valid & w_long_op));
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pending_q <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    case (w_op)
                        OP_MULT, OP_MULTU: begin
                            pending_d = w_prod;
                            cnt_d     = MD_MULT_LAT;
                            state_d   = MUL_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pending_d = {w_rem, w_quot};
                            cnt_d     = w_div_lat;
                            state_d   = DIV_RUN;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                cnt_d = cnt_q - 4'd1;
                // Commit on the edge where the counter lands on zero.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    hi_d    = pending_q[63:32];
                    lo_d    = pending_q[31:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_md_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_md_scheduler : directed vectors plus a cycle-level reference model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_md_scheduler;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        id_md_use;
    logic        req_ready;
    logic        busy;
    logic        stall_id;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic chk_en = 1'b0;

`ifdef MD_DIV0_FAST_EN
    localparam int DIV0_CYC = 1;
`else
    localparam int DIV0_CYC = 10;
`endif

    md_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .id_md_use (id_md_use),
        .req_ready (req_ready),
        .busy      (busy),
        .stall_id  (stall_id),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Reference model: remaining busy cycles plus the {hi,lo} result to land.
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] u;
        case (op)
            3'd1: begin x = longint'($signed(a)) * longint'($signed(b)); return x; end
            3'd2: begin u = {32'd0, a} * {32'd0, b}; return u; end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                x = (op == 3'd3) ? longint'($signed(a)) : longint'({32'd0, a});
                y = (op == 3'd3) ? longint'($signed(b)) : longint'({32'd0, b});
                q = x / y;
                r = x % y;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_res = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
        end else if (req_valid) begin
            case (req_op)
                3'd1, 3'd2: begin m_res = ref_result(req_op, rs_data, rt_data); m_rem = 5; end
                3'd3, 3'd4: begin
                    m_res = ref_result(req_op, rs_data, rt_data);
                    m_rem = (rt_data == 32'd0) ? DIV0_CYC : 10;
                end
                3'd5: m_hi = rs_data;
                3'd6: m_lo = rs_data;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_busy;
            exp_busy = (m_rem > 0);
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("req_ready", {31'd0, req_ready}, {31'd0, !exp_busy});
            check("stall_id", {31'd0, stall_id},
                  {31'd0, id_md_use & (exp_busy | (req_valid & (req_op >= 3'd1) & (req_op <= 3'd4)))});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
    endtask

    // Counts negedges with busy high, bounded so a stuck DUT still terminates.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0;
        rs_data = '0; rt_data = '0; id_md_use = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", {31'd0, stall_id}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        count_busy(n);
        check("mult_busy_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        issue(OP_DIVU, 32'd100, 32'd7);
        req_valid = 1'b1; req_op = OP_DIV; rs_data = 32'd9; rt_data = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_req_ready", {31'd0, req_ready}, 32'd0);
            check("busy_hi_hold", hi, 32'hFFFF_FFFF);
            check("busy_lo_hold", lo, 32'hFFFF_FFFA);
        end
        @(posedge clk); #1 req_valid = 1'b0; req_op = 3'd0;
        count_busy(n);
        check("divu_busy_cycles", n + 3, 32'd10);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        id_md_use = 1'b1;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_busy", {31'd0, stall_id}, 32'd1);
        end
        @(negedge clk);
        check("stall_after", {31'd0, stall_id}, 32'd0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        @(posedge clk); #1 id_md_use = 1'b0;

        issue(OP_DIV, 32'd5, 32'd0);
        count_busy(n);
        check("div0_busy_cycles", n, DIV0_CYC);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'd5);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        count_busy(n);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'd1);

        issue(OP_DIVU, 32'd7, 32'd0);
        count_busy(n);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd7);

        issue(OP_MTHI, 32'h1234, 32'd0);
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(OP_MTLO, 32'h5678, 32'd0);
        issue(OP_NONE, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        check("mtlo_lo", lo, 32'h5678);
        check("none_hi", hi, 32'h1234);

        issue(OP_MULT, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_run_busy", {31'd0, busy}, 32'd0);
        check("rst_run_hi", hi, 32'd0);
        check("rst_run_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        check("rst_run_no_commit_lo", lo, 32'd0);

        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b1; req_op = OP_MULT; rs_data = 32'd6; rt_data = 32'd7;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; req_op = 3'd0;
        @(negedge clk);
        check("rst_wins_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        check("rst_wins_lo", lo, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 The block SHALL have these ports, one per line:
  clk  in  1  pipeline clock, rising edge
  reset  in  1  synchronous, active-high
  req_valid  in  1  EX-stage HI/LO-writing instruction present
  req_op  in  3  md_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
  rs_data  in  32  forwarded rs operand
  rt_data  in  32  forwarded rt operand
  id_md_use  in  1  ID-stage instruction is any MD op or MFHI/MFLO
  req_ready  out  1  request accepted this cycle
  busy  out  1  multi-cycle operation in flight
  stall_id  out  1  hold IF/ID, bubble into EX
  hi  out  32  architectural HI
  lo  out  32  architectural LO
REQ-002 Reset is reset, synchronous, active-high; clock is clk.

Function
REQ-003 The block SHALL implement three states: IDLE, MUL_RUN, DIV_RUN.
REQ-004 The block SHALL assert req_ready = !busy; a request SHALL be accepted only at a rising edge where req_valid & req_ready.
REQ-005 MULT/MULTU accepted at edge T SHALL latch the 64-bit signed/unsigned product into pending registers, load counter = 5, and move to MUL_RUN.
REQ-006 DIV/DIVU accepted at edge T SHALL latch quotient/remainder (signed: truncate toward zero, remainder takes the dividend's sign), load counter = 10, and move to DIV_RUN.
REQ-007 busy SHALL be high exactly N cycles after the accept edge (N = 5 mult, 10 div), where busy = (state != IDLE).
REQ-008 The counter SHALL decrement once per cycle in a RUN state; on the edge where it reaches 0 the block SHALL commit HI = pending[63:32] (div: remainder), LO = pending[31:0] (div: quotient), and return to IDLE.
REQ-009 hi/lo SHALL show the new values from the first cycle busy is low.
REQ-010 MTHI/MTLO accepted in IDLE SHALL write rs_data to HI/LO at that edge, without entering a RUN state.
REQ-011 A request with req_valid=1 while busy SHALL NOT be accepted; HI/LO and the pending registers SHALL stay unchanged.
REQ-012 The block SHALL drive stall_id = id_md_use & (busy | (req_valid & (req_op is MULT/MULTU/DIV/DIVU))).
REQ-013 Divide by zero (rt_data == 0), signed or unsigned, SHALL give LO = 32'hFFFFFFFF and HI = rs_data.
REQ-014 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO = 32'h80000000 and HI = 0.
REQ-015 req_op = NONE SHALL have no effect.
REQ-016 hi/lo SHALL never be X.

Reset
REQ-017 On reset the block SHALL set state = IDLE, counter = 0, pending = 0, HI = LO = 0, busy = 0, and stall_id = 0.
REQ-018 Reset during MUL_RUN/DIV_RUN SHALL discard the in-flight result; no commit SHALL occur.
REQ-019 Reset SHALL win over a same-edge accept.

Configuration
REQ-020 The macro MD_DIV0_FAST_EN SHALL control divide-by-zero latency.
  - Defined: DIV/DIVU with rt_data == 0 SHALL load counter = 1 (busy for exactly 1 cycle), with the REQ-013 results.
  - Undefined: divide by zero SHALL take the normal 10 cycles.

Structure
REQ-021 The shared package md_pkg SHALL hold md_op_t, the constants MD_MULT_LAT = 5 and MD_DIV_LAT = 10, and the state enum.
REQ-022 The sub-module md_arith SHALL hold all combinational product, quotient and remainder logic, including the REQ-013 and REQ-014 special cases.
REQ-023 FSM, counter, HI/LO and stall logic SHALL reside in md_scheduler.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - MULT rs=32'hFFFFFFFE, rt=3 -> busy for 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
  - DIVU rs=100, rt=7 -> busy for 10 cycles; then LO=14, HI=2. A second DIV presented during busy -> req_ready=0, HI/LO unchanged.
  - DIV rs=-7, rt=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. Also: id_md_use=1 during busy -> stall_id=1 on each busy cycle, 0 after.
  - DIV rt=0, rs=5 -> LO=32'hFFFFFFFF, HI=5; busy 1 cycle with MD_DIV0_FAST_EN defined, 10 cycles without.
  - MTHI rs=32'h1234 in IDLE -> hi=32'h1234 next cycle, busy stays 0.
  - MULT accepted, reset asserted on cycle 3 -> busy=0, HI=LO=0, no later commit.
